// File: rtl/uart_hex_formatter.sv
// Formats 32-bit words as ASCII hex lines for the FIFO-buffered UART transmitter.
// Define UART_HEX_PREFIX_EN to start every line with "0x".
module uart_hex_formatter #(
    parameter int NDIGITS   = 8,
    parameter bit UPPERCASE = 1'b1,
    parameter bit SEND_CRLF = 1'b1
) (
    input  logic        clk_100MHz,
    input  logic        reset,
    input  logic        word_valid,
    input  logic [31:0] word_data,
    output logic        word_ready,
    output logic        dat_en,
    output logic [7:0]  dat,
    input  logic        fifo_full,
    output logic        busy
);

    typedef enum logic [2:0] {IDLE, PFX0, PFX1, DIG, CR, LF} state_t;

    localparam logic [2:0] LAST_IDX = 3'(NDIGITS - 1);

    state_t      r_state;
    logic [31:0] r_word;
    logic [2:0]  r_idx;
    logic        r_dat_en;
    logic [7:0]  r_dat;

    logic [3:0]  w_nibble;
    logic [7:0]  w_digit;
    logic        w_emit;

    assign w_nibble = r_word[{r_idx, 2'b00} +: 4];
    assign w_digit  = (w_nibble < 4'd10) ? (8'h30 + {4'h0, w_nibble})
                    : ((UPPERCASE ? 8'h37 : 8'h57) + {4'h0, w_nibble});

    // Gating on the registered strobe keeps fifo_full off any combinational path to dat_en
    // and forces the one-idle-cycle spacing between bytes.
    assign w_emit = !r_dat_en && !fifo_full;

    assign word_ready = (r_state == IDLE);
    assign busy       = (r_state != IDLE);
    assign dat_en     = r_dat_en;
    assign dat        = r_dat;

    // NOTE: all state uses non-blocking assignments so every branch sees pre-edge values.
    always_ff @(posedge clk_100MHz) begin
        if (reset) begin
            r_state  <= IDLE;
            r_word   <= 32'h0;
            r_idx    <= 3'd0;
            r_dat_en <= 1'b0;
            r_dat    <= 8'h00;
        end else begin
            r_dat_en <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (word_valid) begin
                        r_word <= word_data;
                        r_idx  <= LAST_IDX;
`ifdef UART_HEX_PREFIX_EN
                        r_state <= PFX0;
`else
                        r_state <= DIG;
`endif
                    end
                end
                PFX0: begin
                    if (w_emit) begin
                        r_dat_en <= 1'b1;
                        r_dat    <= 8'h30;
                        r_state  <= PFX1;
                    end
                end
                PFX1: begin
                    if (w_emit) begin
                        r_dat_en <= 1'b1;
                        r_dat    <= 8'h78;
                        r_state  <= DIG;
                    end
                end
                DIG: begin
                    if (w_emit) begin
                        r_dat_en <= 1'b1;
                        r_dat    <= w_digit;
                        if (r_idx == 3'd0) begin
                            if (SEND_CRLF) r_state <= CR;
                            else           r_state <= IDLE;
                        end else begin
                            r_idx <= r_idx - 3'd1;
                        end
                    end
                end
                CR: begin
                    if (w_emit) begin
                        r_dat_en <= 1'b1;
                        r_dat    <= 8'h0D;
                        r_state  <= LF;
                    end
                end
                LF: begin
                    if (w_emit) begin
                        r_dat_en <= 1'b1;
                        r_dat    <= 8'h0A;
                        r_state  <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_hex_formatter.sv
// Scoreboard bench for uart_hex_formatter: default instance plus a 2-digit lowercase,
// no-CRLF instance; expected bytes come from a table-driven hex model.
module tb_uart_hex_formatter;

    logic        clk_100MHz = 1'b0;
    logic        reset;
    logic        valid0, valid1;
    logic [31:0] data0, data1;
    logic        ready0, ready1;
    logic        en0, en1;
    logic [7:0]  dat0, dat1;
    logic        full0;
    logic        busy0, busy1;

    logic [7:0] q0[$];
    logic [7:0] q1[$];
    int n_cmp = 0;
    int n_err = 0;
    int n_bytes0 = 0;
    int n_bytes1 = 0;
    logic prev_en0 = 1'b0;
    logic prev_en1 = 1'b0;

    always #5 clk_100MHz = ~clk_100MHz;

    uart_hex_formatter dut (
        .clk_100MHz(clk_100MHz), .reset(reset),
        .word_valid(valid0), .word_data(data0), .word_ready(ready0),
        .dat_en(en0), .dat(dat0), .fifo_full(full0), .busy(busy0)
    );

    uart_hex_formatter #(.NDIGITS(2), .UPPERCASE(1'b0), .SEND_CRLF(1'b0)) dut2 (
        .clk_100MHz(clk_100MHz), .reset(reset),
        .word_valid(valid1), .word_data(data1), .word_ready(ready1),
        .dat_en(en1), .dat(dat1), .fifo_full(1'b0), .busy(busy1)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic void push_line(input int which, input logic [31:0] w);
        string hu = "0123456789ABCDEF";
        string hl = "0123456789abcdef";
        int nd = (which == 0) ? 8 : 2;
        logic [7:0] b;
        logic [3:0] n;
`ifdef UART_HEX_PREFIX_EN
        if (which == 0) begin q0.push_back(8'h30); q0.push_back(8'h78); end
        else            begin q1.push_back(8'h30); q1.push_back(8'h78); end
`endif
        for (int i = nd - 1; i >= 0; i--) begin
            n = 4'((w >> (4 * i)) & 32'hF);
            b = (which == 0) ? hu[n] : hl[n];
            if (which == 0) q0.push_back(b);
            else            q1.push_back(b);
        end
        if (which == 0) begin q0.push_back(8'h0D); q0.push_back(8'h0A); end
    endfunction

    // Output monitors: pop and compare each strobed byte.
    always @(negedge clk_100MHz) begin
        if (en0) begin
            check("en0_gap", {31'h0, prev_en0}, 32'h0);
            if (q0.size() == 0) check("spurious0", q0.size(), 1);
            else                check("byte0", {24'h0, dat0}, {24'h0, q0.pop_front()});
            n_bytes0++;
        end
        if (en1) begin
            check("en1_gap", {31'h0, prev_en1}, 32'h0);
            if (q1.size() == 0) check("spurious1", q1.size(), 1);
            else                check("byte1", {24'h0, dat1}, {24'h0, q1.pop_front()});
            n_bytes1++;
        end
        prev_en0 = en0;
        prev_en1 = en1;
    end

    task automatic tick();
        @(negedge clk_100MHz);
        #1;
    endtask

    task automatic wait_ready(input int which);
        int n = 0;
        while (((which == 0) ? ready0 : ready1) !== 1'b1 && n < 300) begin tick(); n++; end
        if (n >= 300) check("ready_timeout", {31'h0, (which == 0) ? ready0 : ready1}, 32'h1);
    endtask

    // Returns just after the accepting edge.
    task automatic send(input int which, input logic [31:0] w);
        push_line(which, w);
        if (which == 0) begin valid0 = 1'b1; data0 = w; end
        else            begin valid1 = 1'b1; data1 = w; end
        wait_ready(which);
        tick();
        if (which == 0) begin valid0 = 1'b0; data0 = $urandom; end
        else            begin valid1 = 1'b0; data1 = $urandom; end
    endtask

    task automatic drain(input string tag);
        int n = 0;
        while ((q0.size() != 0 || q1.size() != 0 || !ready0 || !ready1) && n < 500) begin
            tick(); n++;
        end
        if (n >= 500) check(tag, q0.size() + q1.size(), 0);
    endtask

    task automatic wait_bytes0(input int target);
        int n = 0;
        while (n_bytes0 < target && n < 300) begin tick(); n++; end
        if (n_bytes0 < target) check("bytes_timeout", n_bytes0, target);
    endtask

    initial begin
        int nb;
        int base;
        reset = 1'b1; valid0 = 1'b0; valid1 = 1'b0;
        data0 = 32'h0; data1 = 32'h0; full0 = 1'b0;
        repeat (3) tick();
        check("rst_en",    {31'h0, en0},    32'h0);
        check("rst_dat",   {24'h0, dat0},   32'h0);
        check("rst_ready", {31'h0, ready0}, 32'h1);
        check("rst_busy",  {31'h0, busy0},  32'h0);
        reset = 1'b0;
        tick();

        // Basic line: latency, strobe spacing, word_ready low until last byte.
        send(0, 32'h1234ABCD);
        nb = q0.size();
        check("latency_pre", {31'h0, en0}, 32'h0);
        for (int k = 0; k < 2 * nb; k++) begin
            tick();
            check("en_pattern", {31'h0, en0}, (k % 2 == 0) ? 32'h1 : 32'h0);
            check("ready_hold", {31'h0, ready0}, (k >= 2 * nb - 2) ? 32'h1 : 32'h0);
        end
        drain("drain_basic");

        // Prefix/uppercase digits and boundary words.
        send(0, 32'h0000000F);
        drain("drain_0f");
        send(0, 32'h00000000);
        send(0, 32'hFFFFFFFF);
        send(0, $urandom);
        drain("drain_bounds");

        // Back-pressure after the 3rd byte.
        base = n_bytes0;
        send(0, 32'h9A5C3E71);
        wait_bytes0(base + 3);
        full0 = 1'b1;
        for (int k = 0; k < 50; k++) begin
            tick();
            check("stall_en", {31'h0, en0}, 32'h0);
        end
        check("stall_count", n_bytes0, base + 3);
        full0 = 1'b0;
        drain("drain_stall");

        // Reduced instance: 2 lowercase digits, no CRLF.
        send(1, 32'hDEAD00FF);
        drain("drain_dut2");
        check("dut2_ready", {31'h0, ready1}, 32'h1);
        check("dut2_busy",  {31'h0, busy1},  32'h0);
        check("dut2_count", n_bytes1, 2);

        // word_valid held across two different words.
        push_line(0, 32'hCAFEBABE);
        valid0 = 1'b1; data0 = 32'hCAFEBABE;
        wait_ready(0);
        tick();
        check("b2b_busy", {31'h0, ready0}, 32'h0);
        push_line(0, 32'h0BADF00D);
        data0 = 32'h0BADF00D;
        wait_ready(0);
        tick();
        valid0 = 1'b0;
        drain("drain_b2b");

        // Reset in the middle of the digits aborts the line.
        base = n_bytes0;
        send(0, 32'h87654321);
        wait_bytes0(base + 3);
        tick();
        reset = 1'b1;
        q0.delete();
        tick();
        check("midrst_en",    {31'h0, en0},    32'h0);
        check("midrst_busy",  {31'h0, busy0},  32'h0);
        check("midrst_ready", {31'h0, ready0}, 32'h1);
        reset = 1'b0;
        tick();
        send(0, 32'h13579BDF);
        drain("drain_after_rst");

        repeat (4) tick();
        check("final_q0", q0.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
